// File: rtl/clk_period_meter.sv
// Purpose: measure period and high time of a slow asynchronous square wave in Clk cycles.
// Latency: result registered on the rise-detect cycle, SYNC_STAGES+1 cycles after the SigIn rise.
// Backpressure: Valid holds until Ack; an unacked result that gets overwritten raises Overrun.
// Optional: define PERIOD_AVG4_EN to publish the truncated average of every 4 measurements.
module clk_period_meter #(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             SigIn,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime,
  output logic             Valid,
  input  logic             Ack,
  output logic             Overrun,
  output logic             Timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sig_s;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             hi_phase_q;

  // FSM strobes: start a new period, complete a measurement, stall detected
  logic start;
  logic done;
  logic tmo;

  // Result to publish this cycle (individual or averaged)
  logic             pub;
  logic [CNT_W-1:0] pub_period;
  logic [CNT_W-1:0] pub_high;

  // Both edges see the same chain depth, so period and high time carry no bias.
  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~hist_q;
  assign fall  = ~sig_s & hist_q;

  // Synchroniser chain followed by one history flop for edge detection
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SigIn};
      hist_q <= sig_s;
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; dropping En abandons whatever is in flight
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (En) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (rise) begin
          start   = 1'b1;
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          done  = 1'b1;
          start = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          tmo     = 1'b1;
          state_d = ARM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!En) begin
      state_d = IDLE;
      start   = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
    end
  end

  // Period and high-time counters; zero whenever no measurement continues into next cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q      <= '0;
      hcnt_q     <= '0;
      hi_phase_q <= 1'b0;
    end else if (start) begin
      cnt_q      <= CNT_W'(1);
      hcnt_q     <= CNT_W'(1);
      hi_phase_q <= 1'b1;
    end else if (state_q == MEAS && state_d == MEAS) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (fall) begin
        hi_phase_q <= 1'b0;
      end else if (hi_phase_q) begin
        hcnt_q <= hcnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q      <= '0;
      hcnt_q     <= '0;
      hi_phase_q <= 1'b0;
    end
  end

`ifdef PERIOD_AVG4_EN
  // Two guard bits hold the sum of four full-range measurements.
  logic [CNT_W+1:0] sum_q;
  logic [CNT_W+1:0] hsum_q;
  logic [CNT_W+1:0] sum_nx;
  logic [CNT_W+1:0] hsum_nx;
  logic [1:0]       sub_q;

  // Sums including the measurement completing now; publish on the fourth
  always_comb begin
    sum_nx     = sum_q + {2'b00, cnt_q};
    hsum_nx    = hsum_q + {2'b00, hcnt_q};
    pub        = done && (sub_q == 2'd3);
    pub_period = sum_nx[CNT_W+1:2];
    pub_high   = hsum_nx[CNT_W+1:2];
  end

  // Accumulators restart on reset, idle, disable, timeout and after each average
  always_ff @(posedge Clk) begin
    if (Rst || state_q == IDLE || tmo || !En) begin
      sum_q  <= '0;
      hsum_q <= '0;
      sub_q  <= 2'd0;
    end else if (done) begin
      if (sub_q == 2'd3) begin
        sum_q  <= '0;
        hsum_q <= '0;
        sub_q  <= 2'd0;
      end else begin
        sum_q  <= sum_nx;
        hsum_q <= hsum_nx;
        sub_q  <= sub_q + 2'd1;
      end
    end
  end
`else
  // Every completed measurement is published as-is
  always_comb begin
    pub        = done;
    pub_period = cnt_q;
    pub_high   = hcnt_q;
  end
`endif

  // Result registers and valid/ack handshake; a new result wins over a same-cycle Ack
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Period   <= '0;
      HighTime <= '0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
    end else if (pub) begin
      Period   <= pub_period;
      HighTime <= pub_high;
      Valid    <= 1'b1;
      Overrun  <= Valid & ~Ack;
    end else if (Valid && Ack) begin
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end
  end

  // Sticky stall flag, cleared by the next completed measurement
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Timeout <= 1'b0;
    end else if (done) begin
      Timeout <= 1'b0;
    end else if (tmo) begin
      Timeout <= 1'b1;
    end
  end

endmodule
